shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Iterative sequencer for shift instructions (SLL/SRL/SRA) that reuses one single-bit shift stage every cycle instead of a 32-stage mux chain.
- Accepts an operand and shift amount through a valid/ready handshake and iterates one bit per cycle until done.
- Holds the result until the consumer accepts it.
- Sits in the execute stage beside the ALU; the pipeline stalls on busy_o.

Parameters:
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width; only rs2_i[SHW-1:0] is used.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- valid_i  input  1  request valid.
- ready_o  output  1  controller can accept a request.
- op_i  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved.
- rs1_i  input  XLEN  operand to shift.
- rs2_i  input  XLEN  shift amount source; low SHW bits used.
- kill_i  input  1  pipeline flush; aborts any operation in progress.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- rd_o  output  XLEN  shifted result.
- busy_o  output  1  high in BUSY or DONE.

Behaviour:
- Reset values (asynchronous on rst_i):
  - State = IDLE; ready_o=1; valid_o=0; busy_o=0; rd_o=0.
  - Internal count, op and accumulator registers = 0.
- FSM states are IDLE, BUSY and DONE.
  - ready_o = (state==IDLE); valid_o = (state==DONE).
- IDLE:
  - On valid_i & ready_o, capture acc=rs1_i, op=op_i, cnt=rs2_i[SHW-1:0].
  - If cnt==0 or op==11, go to DONE; otherwise go to BUSY.
- BUSY, one step per cycle:
  - SLL: acc={acc[XLEN-2:0],1'b0}.
  - SRL: acc={1'b0,acc[XLEN-1:1]}.
  - SRA: acc={acc[XLEN-1],acc[XLEN-1:1]}.
  - cnt decrements by 1; when cnt==1 before the step, go to DONE.
- DONE:
  - rd_o=acc, held stable while valid_o & !ready_i.
  - On ready_i, go to IDLE.
  - A new request cannot be accepted in the same cycle as the handoff; ready_o rises the next cycle.
- Latency: valid_o asserts shamt+1 cycles after the accept edge (shamt=0 gives 1 cycle). Throughput is one op per shamt+2 cycles minimum.
- Reserved op 11: result equals rs1_i unchanged, latency 1.
- kill_i:
  - Has priority over all transitions; next state is IDLE and valid_o is 0 the following cycle.
  - acc/rd_o contents are don't-care after a kill.
  - kill_i together with valid_i in IDLE: the request is dropped.
- rst_i mid-operation: immediate return to reset values; the result is lost.
- rd_o is registered, with no combinational path from inputs to any output except ready_o/valid_o from state.
- valid_i in BUSY/DONE is ignored; the requester must hold it until ready_o.

Optional Feature:
- Macro SHIFT_SEQ_FAST_STEP_EN.
- With the macro defined:
  - Each BUSY cycle with cnt>=4 shifts by 4 (same fill rules) and decrements cnt by 4; otherwise it shifts by 1.
  - Latency = (shamt>>2)+(shamt&3)+1.
- Without the macro: one bit per cycle, latency shamt+1.
- Results are identical in both builds.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic[1:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_RSV};
  - typedef enum logic[1:0] shift_state_e {S_IDLE, S_BUSY, S_DONE};
  - localparam XLEN_DEF=32.
- One sub-module, shift_step: combinational, takes acc, op and a 1-or-4 step select, and returns the next acc (fill logic lives here).

Test Plan:
- Reset: assert rst_i mid-BUSY → next cycle ready_o=1, valid_o=0, rd_o=0, busy_o=0.
- SLL: rs1=0x0000_0001, rs2=31, ready_i=1 → valid_o after 32 cycles, rd_o=0x8000_0000.
- SRA vs SRL: rs1=0xF000_0000, shamt=4 → SRA gives 0xFF00_0000 and SRL gives 0x0F00_0000; each has valid_o 5 cycles after accept.
- Zero shift and reserved op:
  - rs1=0xDEAD_BEEF, shamt=0, op=SLL → rd_o=0xDEAD_BEEF after 1 cycle.
  - op=11, shamt=7 → same result and latency.
- Backpressure: result ready with ready_i=0 for 5 cycles → rd_o and valid_o stable; the new valid_i is not accepted until the cycle after ready_i=1.
- kill_i at BUSY cycle 3 of a shamt=10 op → IDLE next cycle and valid_o never asserts. With SHIFT_SEQ_FAST_STEP_EN, shamt=10 SLL of 0x1 gives 0x400 with latency 5.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// shift_pkg: shared types for the iterative shift sequencer.
// The operation and FSM encodings live here so the top, the step
// datapath and the interface all agree on them.
package shift_pkg;

   // Default operand width.
   localparam int XLEN_DEF = 32;

   // Shift operation. SH_RSV passes the operand through unchanged.
   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10,
      SH_RSV = 2'b11
   } shift_op_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } shift_state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle for shift_seq_ctrl.
// Signal names follow the controller's point of view (_i into it, _o out of it).
// slave  : the sequencer itself.
// master : the execute-stage requester / result consumer.
interface shift_seq_ctrl_if #(
   parameter int XLEN = 32
);
   // request side
   logic            valid_i;
   logic            ready_o;
   logic [1:0]      op_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            kill_i;
   // response side
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] rd_o;
   logic            busy_o;

   modport slave (
      input  valid_i, op_i, rs1_i, rs2_i, kill_i, ready_i,
      output ready_o, valid_o, rd_o, busy_o
   );

   modport master (
      output valid_i, op_i, rs1_i, rs2_i, kill_i, ready_i,
      input  ready_o, valid_o, rd_o, busy_o
   );
endinterface

// File: rtl/shift_seq_ctrl_step.sv
// shift_step: one iteration of the shift datapath.
// Shifts the accumulator by 1 or by 4 positions. Fill bits are zero for
// SLL/SRL and the sign bit for SRA; the reserved op passes through.
module shift_step
   import shift_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] acc_i,
   input  shift_op_e       op_i,
   input  logic            step4_i,   // 1: shift by 4, 0: shift by 1
   output logic [XLEN-1:0] acc_o
);

   logic sign;
   assign sign = acc_i[XLEN-1];

   // Next accumulator value for the selected op and step size.
   always_comb begin
      acc_o = acc_i;
      case (op_i)
         SH_SLL: acc_o = step4_i ? {acc_i[XLEN-5:0], 4'b0000}
                                 : {acc_i[XLEN-2:0], 1'b0};
         SH_SRL: acc_o = step4_i ? {4'b0000, acc_i[XLEN-1:4]}
                                 : {1'b0, acc_i[XLEN-1:1]};
         SH_SRA: acc_o = step4_i ? {{4{sign}}, acc_i[XLEN-1:4]}
                                 : {sign, acc_i[XLEN-1:1]};
         default: acc_o = acc_i;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: iterative SLL/SRL/SRA sequencer for the execute stage.
// A request is captured in IDLE, the accumulator is shifted one position
// per cycle in BUSY, and the result is held in DONE until the consumer
// takes it. kill_i aborts anything in flight; the pipeline stalls on busy_o.
// Optional build macro: SHIFT_SEQ_FAST_STEP_EN -- BUSY cycles with a
// remaining count of at least 4 shift by 4 instead of 1. Results match
// the default build; only latency changes.
module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int SHW  = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   shift_seq_ctrl_if.slave bus
);

   shift_state_e    state_q;
   shift_op_e       op_q;
   logic [SHW-1:0]  cnt_q;
   logic [XLEN-1:0] acc_q;

   logic [SHW-1:0]  cnt_d;
   logic [XLEN-1:0] acc_d;
   logic [SHW-1:0]  step_amt;
   logic            step4;
   logic [SHW-1:0]  req_cnt;
   shift_op_e       req_op;

   // Only the low SHW bits of rs2 carry the shift amount.
   logic unused_rs2_hi;
   assign unused_rs2_hi = ^bus.rs2_i[XLEN-1:SHW];

   assign req_cnt = bus.rs2_i[SHW-1:0];
   assign req_op  = shift_op_e'(bus.op_i);

`ifdef SHIFT_SEQ_FAST_STEP_EN
   // Take a 4-bit stride while at least 4 positions remain.
   assign step4 = (cnt_q >= SHW'(4));
`else
   assign step4 = 1'b0;
`endif

   assign step_amt = step4 ? SHW'(4) : SHW'(1);
   assign cnt_d    = cnt_q - step_amt;

   shift_step #(
      .XLEN(XLEN)
   ) u_step (
      .acc_i  (acc_q),
      .op_i   (op_q),
      .step4_i(step4),
      .acc_o  (acc_d)
   );

   // Sequencer FSM: capture, iterate, hold. kill_i overrides every transition.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         op_q    <= SH_SLL;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else if (bus.kill_i) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.valid_i) begin
                  acc_q   <= bus.rs1_i;
                  op_q    <= req_op;
                  cnt_q   <= req_cnt;
                  // Nothing to iterate for a zero shift or the pass-through op.
                  state_q <= ((req_cnt == '0) || (req_op == SH_RSV)) ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
               if (cnt_q == step_amt) state_q <= S_DONE;
            end
            S_DONE: begin
               // Handoff cycle; ready_o only rises once we are back in IDLE.
               if (bus.ready_i) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs come straight from registers / state decode.
   assign bus.ready_o = (state_q == S_IDLE);
   assign bus.valid_o = (state_q == S_DONE);
   assign bus.busy_o  = (state_q != S_IDLE);
   assign bus.rd_o    = acc_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl. Expected results come from plain
// shift operators; expected latency from the shift amount.
module tb_shift_seq_ctrl;

   localparam int XLEN = 32;
   localparam int TMO  = 80;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   shift_seq_ctrl_if #(.XLEN(XLEN)) bus ();

   shift_seq_ctrl #(.XLEN(XLEN), .SHW(5)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_rd(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         2'b00:   return a << sh;
         2'b01:   return a >> sh;
         2'b10:   return 32'($signed(a) >>> sh);
         default: return a;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      if (op == 2'b11 || sh == 0) return 1;
`ifdef SHIFT_SEQ_FAST_STEP_EN
      return (sh / 4) + (sh % 4) + 1;
`else
      return sh + 1;
`endif
   endfunction

   // ---------------- stimulus driver ----------------
   // Entered with the DUT idle, just after a rising edge. Presents one
   // request, measures edges from accept (counted as 1) to valid_o, captures
   // rd_o, then hands off with ready_i=1 and returns just after that edge.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
      bus.valid_i = 1'b1;
      bus.op_i    = op;
      bus.rs1_i   = a;
      bus.rs2_i   = b;
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
      r = bus.rd_o;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] r;
      rst = 1'b1;
      #12;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.rd_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_init: ready=%b valid=%b busy=%b rd=%h, want 1 0 0 0",
                  bus.ready_o, bus.valid_o, bus.busy_o, bus.rd_o);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      // start a long op and reset it mid-BUSY
      bus.valid_i = 1'b1; bus.op_i = 2'b01; bus.rs1_i = 32'hFFFF_0000; bus.rs2_i = 32'd20;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (bus.busy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_busy: busy=%b want 1", bus.busy_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.rd_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_busy: ready=%b valid=%b busy=%b rd=%h, want 1 0 0 0",
                  bus.ready_o, bus.valid_o, bus.busy_o, bus.rd_o);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: ready=%b valid=%b busy=%b want 1 0 0",
                  bus.ready_o, bus.valid_o, bus.busy_o);
      end
      r = 32'h0;
   endtask

   task automatic test_sll();
      logic [31:0] r;
      int lat;
      run_op(2'b00, 32'h0000_0001, 32'd31, r, lat);
      checks++;
      if (r !== 32'h8000_0000 || lat != model_lat(2'b00, 32'd31)) begin
         errors++;
         $display("FAIL sll31: rd=%h lat=%0d want %h lat=%0d", r, lat, 32'h8000_0000, model_lat(2'b00, 32'd31));
      end
      run_op(2'b00, 32'h0000_0001, 32'd10, r, lat);
      checks++;
      if (r !== 32'h0000_0400 || lat != model_lat(2'b00, 32'd10)) begin
         errors++;
         $display("FAIL sll10: rd=%h lat=%0d want %h lat=%0d", r, lat, 32'h400, model_lat(2'b00, 32'd10));
      end
   endtask

   task automatic test_sra_srl();
      logic [31:0] r;
      int lat;
      run_op(2'b10, 32'hF000_0000, 32'd4, r, lat);
      checks++;
      if (r !== 32'hFF00_0000 || lat != model_lat(2'b10, 32'd4)) begin
         errors++;
         $display("FAIL sra4: rd=%h lat=%0d want %h lat=%0d", r, lat, 32'hFF00_0000, model_lat(2'b10, 32'd4));
      end
      run_op(2'b01, 32'hF000_0000, 32'd4, r, lat);
      checks++;
      if (r !== 32'h0F00_0000 || lat != model_lat(2'b01, 32'd4)) begin
         errors++;
         $display("FAIL srl4: rd=%h lat=%0d want %h lat=%0d", r, lat, 32'h0F00_0000, model_lat(2'b01, 32'd4));
      end
   endtask

   task automatic test_zero_rsv();
      logic [31:0] r;
      int lat;
      run_op(2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFE0, r, lat);   // low 5 bits zero
      checks++;
      if (r !== 32'hDEAD_BEEF || lat != 1) begin
         errors++;
         $display("FAIL zero_shift: rd=%h lat=%0d want deadbeef lat=1", r, lat);
      end
      run_op(2'b11, 32'hDEAD_BEEF, 32'd7, r, lat);
      checks++;
      if (r !== 32'hDEAD_BEEF || lat != 1) begin
         errors++;
         $display("FAIL reserved_op: rd=%h lat=%0d want deadbeef lat=1", r, lat);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r0;
      int lat;
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1; bus.op_i = 2'b01; bus.rs1_i = 32'h8765_4321; bus.rs2_i = 32'd3;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
      r0 = bus.rd_o;
      checks++;
      if (r0 !== model_rd(2'b01, 32'h8765_4321, 32'd3) || lat != model_lat(2'b01, 32'd3)) begin
         errors++;
         $display("FAIL bp_result: rd=%h lat=%0d want %h lat=%0d", r0, lat,
                  model_rd(2'b01, 32'h8765_4321, 32'd3), model_lat(2'b01, 32'd3));
      end
      // new request waits while the result is held
      bus.valid_i = 1'b1; bus.op_i = 2'b00; bus.rs1_i = 32'h0000_0001; bus.rs2_i = 32'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.valid_o !== 1'b1 || bus.rd_o !== r0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b rd=%h ready=%b busy=%b want 1 %h 0 1",
                     i, bus.valid_o, bus.rd_o, bus.ready_o, bus.busy_o, r0);
         end
      end
      bus.ready_i = 1'b1;
      @(posedge clk); #1;   // handoff edge: new request must not be taken here
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_handoff: valid=%b ready=%b busy=%b want 0 1 0",
                  bus.valid_o, bus.ready_o, bus.busy_o);
      end
      @(posedge clk); #1;   // accept edge
      bus.valid_i = 1'b0;
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (bus.rd_o !== 32'h0000_0004 || lat != model_lat(2'b00, 32'd2)) begin
         errors++;
         $display("FAIL bp_next: rd=%h lat=%0d want 00000004 lat=%0d", bus.rd_o, lat, model_lat(2'b00, 32'd2));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_kill();
      int seen;
      bus.ready_i = 1'b1;
      bus.valid_i = 1'b1; bus.op_i = 2'b00; bus.rs1_i = 32'h1; bus.rs2_i = 32'd10;
      @(posedge clk); #1;   // accept; BUSY cycle 1 follows
      bus.valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.kill_i = 1'b1;    // during BUSY cycle 3
      @(posedge clk); #1;
      bus.kill_i = 1'b0;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL kill_busy: ready=%b valid=%b busy=%b want 1 0 0", bus.ready_o, bus.valid_o, bus.busy_o);
      end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (bus.valid_o === 1'b1 || bus.busy_o === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL kill_quiet: active cycles=%0d want 0", seen);
      end
      // kill together with a request in IDLE drops the request
      bus.valid_i = 1'b1; bus.kill_i = 1'b1; bus.rs2_i = 32'd0;
      @(posedge clk); #1;
      bus.valid_i = 1'b0; bus.kill_i = 1'b0;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
         errors++;
         $display("FAIL kill_idle: ready=%b busy=%b valid=%b want 1 0 0", bus.ready_o, bus.busy_o, bus.valid_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r, a, b;
      logic [1:0] op;
      int lat;
      for (int i = 0; i < 4; i++) begin
         op = 2'(i);
         a  = $urandom;
         b  = $urandom_range(0, 31);
         run_op(op, a, b, r, lat);
         checks++;
         if (r !== model_rd(op, a, b) || lat != model_lat(op, b) || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b[%0d]: op=%0d a=%h sh=%0d rd=%h lat=%0d ready=%b want %h lat=%0d ready=1",
                     i, op, a, b[4:0], r, lat, bus.ready_o, model_rd(op, a, b), model_lat(op, b));
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [1:0] op;
      int lat, stall;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         stall = $urandom_range(0, 3);
         bus.ready_i = 1'b0;
         bus.valid_i = 1'b1; bus.op_i = op; bus.rs1_i = a; bus.rs2_i = b;
         @(posedge clk); #1;
         bus.valid_i = 1'b0;
         lat = 1;
         while (bus.valid_o !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
         end
         repeat (stall) @(posedge clk);
         #1;
         checks++;
         if (bus.valid_o !== 1'b1 || bus.rd_o !== model_rd(op, a, b) || lat != model_lat(op, b)) begin
            errors++;
            $display("FAIL rand[%0d]: op=%0d a=%h sh=%0d valid=%b rd=%h lat=%0d want %h lat=%0d",
                     i, op, a, b[4:0], bus.valid_o, bus.rd_o, lat, model_rd(op, a, b), model_lat(op, b));
         end
         bus.ready_i = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.valid_i = 1'b0;
      bus.op_i    = 2'b00;
      bus.rs1_i   = '0;
      bus.rs2_i   = '0;
      bus.kill_i  = 1'b0;
      bus.ready_i = 1'b1;
      test_reset();
      test_sll();
      test_sra_srl();
      test_zero_rsv();
      test_backpressure();
      test_kill();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
